// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin merges CPU and debug bytes into a FIFO drained into async_transmitter (UART_TX_CRLF_EN: CR before LF).
// Latency: a byte pushed into an empty FIFO with the FSM idle is popped and raises TX_START on the next edge.
// Backpressure: REQn_READY drops while the registered count reads full; the losing requester holds VALID/DATA.
module uart_tx_sched #(
    parameter int FIFO_DEPTH   = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        REQ0_VALID,
    input  logic [7:0]                  REQ0_DATA,
    output logic                        REQ0_READY,
    input  logic                        REQ1_VALID,
    input  logic [7:0]                  REQ1_DATA,
    output logic                        REQ1_READY,
    output logic                        TX_START,
    output logic [7:0]                  TX_DATA,
    input  logic                        TX_BUSY,
    output logic                        TX_READY,
    output logic                        TX_IDLE,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   tmo_q;
    logic            rr_q;
    logic            full, empty;
    logic            grant0, grant1, push, pop, contended;
    logic [7:0]      push_dat, head, launch_dat;
    logic            launch, tmo_clr, tmo_inc;
`ifdef UART_TX_CRLF_EN
    logic            cr_sent_q, cr_set, cr_clr;
`endif

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign head  = mem[rd_ptr];

    // Arbitration only looks at the registered count, so a pop never frees a slot for a same-cycle push.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!full) begin
            if (REQ0_VALID && (!REQ1_VALID || !rr_q)) begin
                grant0 = 1'b1;
            end else if (REQ1_VALID) begin
                grant1 = 1'b1;
            end
        end
    end

    assign push       = grant0 | grant1;
    assign push_dat   = grant0 ? REQ0_DATA : REQ1_DATA;
    assign contended  = REQ0_VALID & REQ1_VALID & push;
    assign REQ0_READY = grant0;
    assign REQ1_READY = grant1;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        launch     = 1'b0;
        launch_dat = head;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
`ifdef UART_TX_CRLF_EN
        cr_set     = 1'b0;
        cr_clr     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    launch  = 1'b1;
                    state_d = S_START;
`ifdef UART_TX_CRLF_EN
                    // LF stays at the head while its CR goes out; the next idle visit pops it.
                    if (head == 8'h0A && !cr_sent_q) begin
                        launch_dat = 8'h0D;
                        cr_set     = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        cr_clr = 1'b1;
                    end
`else
                    pop = 1'b1;
`endif
                end
            end
            S_START: begin
                tmo_clr = 1'b1;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!TX_BUSY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            tmo_q    <= '0;
            rr_q     <= 1'b0;
            TX_START <= 1'b0;
            TX_DATA  <= 8'h00;
            TX_READY <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            TX_READY <= (count_d != DEPTH_C);
            TX_START <= launch;
            if (launch) begin
                TX_DATA <= launch_dat;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (tmo_clr) begin
                tmo_q <= '0;
            end else if (tmo_inc) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (contended) begin
                rr_q <= ~rr_q;
            end
        end
    end

`ifdef UART_TX_CRLF_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cr_sent_q <= 1'b0;
        end else if (cr_set) begin
            cr_sent_q <= 1'b1;
        end else if (cr_clr) begin
            cr_sent_q <= 1'b0;
        end
    end
`endif

    assign TX_IDLE    = empty && (state_q == S_IDLE);
    assign FIFO_COUNT = count_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue/age-based reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_sched;

    localparam int DEPTH = 8;
    localparam int BT    = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       REQ0_VALID = 1'b0;
    logic [7:0] REQ0_DATA  = 8'h00;
    logic       REQ0_READY;
    logic       REQ1_VALID = 1'b0;
    logic [7:0] REQ1_DATA  = 8'h00;
    logic       REQ1_READY;
    logic       TX_START;
    logic [7:0] TX_DATA;
    logic       TX_BUSY = 1'b0;
    logic       TX_READY;
    logic       TX_IDLE;
    logic [3:0] FIFO_COUNT;

    uart_tx_sched #(.FIFO_DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
        .TX_START(TX_START), .TX_DATA(TX_DATA), .TX_BUSY(TX_BUSY),
        .TX_READY(TX_READY), .TX_IDLE(TX_IDLE), .FIFO_COUNT(FIFO_COUNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: queued bytes, pointer, and age of the byte in flight (-1 = nothing in flight).
    logic [7:0] mq[$];
    int         m_rr, m_age;
    bit         m_seen, m_cr;
    logic [7:0] m_data;

    logic [7:0] pend0[$], pend1[$], sent[$], expq[$];
    int         start_cyc[$];
    int         xmode, xm_cnt, cyc;
    int         n_cmp, n_fail;
    int         both_rdy, rdy0_cnt, rdy0_cyc, drops;
    logic [3:0] prev_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_sent(input string nm);
        check({nm, "_len"}, sent.size(), expq.size());
        for (int i = 0; i < expq.size() && i < sent.size(); i++) begin
            check($sformatf("%s_byte%0d", nm, i), sent[i], expq[i]);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rr   = 0;
        m_age  = -1;
        m_seen = 0;
        m_cr   = 0;
        m_data = 8'h00;
    endtask

    function automatic logic exp_rdy0();
        return REQ0_VALID && (mq.size() < DEPTH) && (!REQ1_VALID || m_rr == 0);
    endfunction

    function automatic logic exp_rdy1();
        return REQ1_VALID && (mq.size() < DEPTH) && !(REQ0_VALID && m_rr == 0);
    endfunction

    task automatic model_step();
        logic g0, g1;
        if (!RST) begin
            model_reset();
        end else begin
            g0 = exp_rdy0();
            g1 = exp_rdy1();
            if (m_age < 0) begin
                if (mq.size() > 0) begin
`ifdef UART_TX_CRLF_EN
                    if (mq[0] == 8'h0A && !m_cr) begin
                        m_data = 8'h0D;
                        m_cr   = 1;
                    end else begin
                        m_data = mq.pop_front();
                        m_cr   = 0;
                    end
`else
                    m_data = mq.pop_front();
`endif
                    m_age  = 0;
                    m_seen = 0;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (!m_seen) begin
                if (TX_BUSY) m_seen = 1;
                else if (m_age >= BT) m_age = -1;
                else m_age++;
            end else if (!TX_BUSY) begin
                m_age = -1;
            end
            if (g0) begin
                mq.push_back(REQ0_DATA);
                void'(pend0.pop_front());
            end
            if (g1) begin
                mq.push_back(REQ1_DATA);
                void'(pend1.pop_front());
            end
            if (REQ0_VALID && REQ1_VALID && (g0 || g1)) m_rr = 1 - m_rr;
        end
    endtask

    // xmode 0: transmitter goes busy for 4 cycles after each start; 1: busy stuck high; 2: busy stuck low.
    task automatic drive();
        if (RST) begin
            REQ0_VALID = (pend0.size() > 0);
            REQ0_DATA  = (pend0.size() > 0) ? pend0[0] : 8'h00;
            REQ1_VALID = (pend1.size() > 0);
            REQ1_DATA  = (pend1.size() > 0) ? pend1[0] : 8'h00;
        end else begin
            REQ0_VALID = 1'b0;
            REQ1_VALID = 1'b0;
        end
        case (xmode)
            1: TX_BUSY = 1'b1;
            2: TX_BUSY = 1'b0;
            default: begin
                if (m_age == 1 && !m_seen && xm_cnt == 0) xm_cnt = 4;
                TX_BUSY = (xm_cnt > 0);
                if (xm_cnt > 0) xm_cnt--;
            end
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            cyc++;
            model_step();
            #1;
            drive();
        end
    end

    initial begin
        prev_cnt = 4'd0;
        forever begin
            @(negedge CLK);
            check("req0_ready", REQ0_READY, exp_rdy0());
            check("req1_ready", REQ1_READY, exp_rdy1());
            check("tx_start",   TX_START,   (m_age == 0));
            check("tx_data",    TX_DATA,    m_data);
            check("fifo_count", FIFO_COUNT, mq.size());
            check("tx_ready",   TX_READY,   (mq.size() < DEPTH));
            check("tx_idle",    TX_IDLE,    (mq.size() == 0 && m_age < 0));
            if (TX_START === 1'b1) begin
                sent.push_back(TX_DATA);
                start_cyc.push_back(cyc);
            end
            if (REQ0_READY === 1'b1 && REQ1_READY === 1'b1) both_rdy++;
            if (REQ0_READY === 1'b1) begin
                rdy0_cnt++;
                rdy0_cyc = cyc;
            end
            if (RST === 1'b1 && FIFO_COUNT < prev_cnt) drops++;
            prev_cnt = FIFO_COUNT;
        end
    end

    task automatic wait_idle(input string nm, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (TX_IDLE === 1'b1 && pend0.size() == 0 && pend1.size() == 0) break;
        end
        check({nm, "_idle_in_budget"}, (i < budget), 1'b1);
    endtask

    task automatic wait_count(input string nm, input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (FIFO_COUNT === 4'(target)) break;
        end
        check({nm, "_count_in_budget"}, (i < budget), 1'b1);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_tx_start"}, TX_START,   1'b0);
        check({nm, "_tx_data"},  TX_DATA,    8'h00);
        check({nm, "_count"},    FIFO_COUNT, 4'd0);
        check({nm, "_tx_ready"}, TX_READY,   1'b1);
        check({nm, "_tx_idle"},  TX_IDLE,    1'b1);
    endtask

    initial begin
        xmode = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b1;

        // Single CPU byte: READY for one cycle, start two cycles after the accepting cycle.
        sent.delete(); start_cyc.delete(); rdy0_cnt = 0;
        pend0.push_back(8'h41);
        wait_idle("single", 100);
        expq = '{8'h41};
        check_sent("single");
        check("single_rdy0_cycles", rdy0_cnt, 1);
        if (start_cyc.size() > 0) check("single_start_latency", start_cyc[0] - rdy0_cyc, 2);
        check("single_idle", TX_IDLE, 1'b1);

        // Contended requesters alternate starting with requester 0.
        @(negedge CLK);
        sent.delete(); both_rdy = 0;
        pend0.push_back(8'h10); pend0.push_back(8'h11);
        pend1.push_back(8'h20); pend1.push_back(8'h21);
        wait_idle("arb", 200);
        expq = '{8'h10, 8'h20, 8'h11, 8'h21};
        check_sent("arb");
        check("arb_double_ready", both_rdy, 0);

        // Stall the transmitter and overfill the FIFO.
        @(negedge CLK);
        sent.delete();
        xmode = 1;
        pend0.push_back(8'h30);
        repeat (6) @(negedge CLK);
        for (int i = 1; i < 10; i++) pend0.push_back(8'(8'h30 + i));
        wait_count("full", 8, 60);
        check("full_tx_ready", TX_READY, 1'b0);
        check("full_valid_held", REQ0_VALID, 1'b1);
        check("full_ready_low", REQ0_READY, 1'b0);
        repeat (5) @(negedge CLK);
        check("full_ninth_waits", pend0.size(), 1);
        check("full_count_held", FIFO_COUNT, 4'd8);
        xmode = 0;
        wait_idle("full", 600);
        expq.delete();
        for (int i = 0; i < 10; i++) expq.push_back(8'(8'h30 + i));
        check_sent("full");

        // TX_BUSY never rises: each byte times out after BT wait cycles.
        @(negedge CLK);
        sent.delete(); start_cyc.delete();
        xmode = 2;
        pend1.push_back(8'h50); pend1.push_back(8'h51);
        wait_idle("tmo", 200);
        expq = '{8'h50, 8'h51};
        check_sent("tmo");
        if (start_cyc.size() == 2) check("tmo_start_spacing", start_cyc[1] - start_cyc[0], 18);

        // Reset while waiting for TX_BUSY to fall with 3 bytes queued.
        @(negedge CLK);
        xmode = 1;
        for (int i = 0; i < 4; i++) pend0.push_back(8'(8'h60 + i));
        wait_count("rst", 3, 60);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        pend0.delete(); pend1.delete();
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        xmode = 0; xm_cnt = 0; TX_BUSY = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        sent.delete();
        repeat (30) @(negedge CLK);
        check("midrst_no_start", sent.size(), 0);

        // LF handling: CR inserted when enabled, verbatim otherwise; exactly two pops either way.
        sent.delete();
        xmode = 1;
        pend0.push_back(8'h7E);
        repeat (6) @(negedge CLK);
        pend0.push_back(8'h61); pend0.push_back(8'h0A);
        wait_count("crlf", 2, 40);
        drops = 0;
        xmode = 0;
        wait_idle("crlf", 300);
`ifdef UART_TX_CRLF_EN
        expq = '{8'h7E, 8'h61, 8'h0D, 8'h0A};
`else
        expq = '{8'h7E, 8'h61, 8'h0A};
`endif
        check_sent("crlf");
        check("crlf_count_drops", drops, 2);

        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
